// File: rtl/alu_packer_pkg.sv
// Shared types and helpers for the ALU result packer.
// Mask packing is compiled in only when ALU_PACKER_MASK_EN is defined.
package alu_packer_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_t;

    typedef struct packed {
        logic [31:0]     data;
        logic [BE_W-1:0] be;
    } packed_word_t;

    function automatic logic [5:0] SLOTS_PER_WORD(
        input sew_t sew,
        input logic mask
    );
        logic [5:0] n;
        if (mask) begin
            n = 6'd32;
        end else begin
            unique case (sew)
                SEW8:    n = 6'd4;
                SEW16:   n = 6'd2;
                default: n = 6'd1;
            endcase
        end
        return n;
    endfunction

    // n is the number of filled slots, 1..32
    function automatic logic [BE_W-1:0] fill_be(
        input sew_t       sew,
        input logic       mask,
        input logic [5:0] n
    );
        logic [5:0]      ceil8;
        logic [2:0]      bytes;
        logic [BE_W-1:0] be;
        ceil8 = (n + 6'd7) >> 3;
        if (mask) begin
            bytes = ceil8[2:0];
        end else begin
            unique case (sew)
                SEW8:    bytes = n[2:0];
                SEW16:   bytes = {n[1:0], 1'b0};
                default: bytes = 3'd4;
            endcase
        end
        unique case (bytes)
            3'd0:    be = 4'b0000;
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/alu_result_packer_if.sv
// Result-stream and VRF write-port bundle for the packer.
// Field names match the packer's external port list.
interface alu_result_packer_if
    import alu_packer_pkg::*;
#(
    parameter int OP_WIDTH        = 32,
    parameter int PARALLEL_IF_NUM = 4
);
    logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] res_i;
    logic [PARALLEL_IF_NUM-1:0]               res_vld_i;
    logic [PARALLEL_IF_NUM-1:0][1:0]          output_sew_i;
    logic [PARALLEL_IF_NUM-1:0]               mask_mode_i;
    logic [PARALLEL_IF_NUM-1:0]               last_i;
    logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] wdata_o;
    logic [PARALLEL_IF_NUM-1:0][BE_W-1:0]     wbe_o;
    logic [PARALLEL_IF_NUM-1:0]               wvld_o;
    logic [PARALLEL_IF_NUM-1:0]               wrdy_i;
    logic [PARALLEL_IF_NUM-1:0]               afull_o;
    logic [PARALLEL_IF_NUM-1:0]               overflow_o;

    modport master (
        output res_i, res_vld_i, output_sew_i,
        output mask_mode_i, last_i, wrdy_i,
        input  wdata_o, wbe_o, wvld_o,
        input  afull_o, overflow_o
    );

    modport slave (
        input  res_i, res_vld_i, output_sew_i,
        input  mask_mode_i, last_i, wrdy_i,
        output wdata_o, wbe_o, wvld_o,
        output afull_o, overflow_o
    );
endinterface

// File: rtl/alu_pack_fifo.sv
// Per-interface FIFO of packed words with occupancy flags.
// A push on a full FIFO is taken only if a pop happens in the same cycle.
module alu_pack_fifo
    import alu_packer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  packed_word_t  din_i,
    input  logic          pop_i,
    output packed_word_t  dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          afull_o
);
    packed_word_t  mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign afull_o = (DEPTH - int'(count_q)) <= AFULL_THRESH;
    assign count_o = count_q;
    assign dout_o  = mem[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= din_i;
    end
endmodule

// File: rtl/alu_result_packer.sv
// Packs per-lane ALU results into 32-bit VRF words with byte enables.
// Mask-bit packing is enabled by defining ALU_PACKER_MASK_EN.
module alu_result_packer
    import alu_packer_pkg::*;
#(
    parameter int OP_WIDTH        = 32,
    parameter int PARALLEL_IF_NUM = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int AFULL_THRESH    = 2
) (
    input logic               clk,
    input logic               rst,
    alu_result_packer_if.slave bus
);
`ifdef ALU_PACKER_MASK_EN
    localparam int SW = 5;
`else
    localparam int SW = 2;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    for (genvar g = 0; g < PARALLEL_IF_NUM; g++) begin : g_lane
        logic [OP_WIDTH-1:0] data_q, data_d, merged;
        logic [SW-1:0]       slot_q, slot_d;
        sew_t                sew_q, sew_d, sew_in, cur_sew;
        logic                cur_mask, done;
        logic [5:0]          fill;
        logic                ovf_q, ovf_d;
        packed_word_t        word, dout;
        logic                pop, full, empty, afull;
        logic [CW-1:0]       fifo_cnt_unused;
`ifdef ALU_PACKER_MASK_EN
        logic                mask_q, mask_d;
`else
        logic                unused_mask;
        assign unused_mask = bus.mask_mode_i[g];
`endif

        always_comb begin
            sew_in = (bus.output_sew_i[g] == 2'b11)
                   ? SEW32 : sew_t'(bus.output_sew_i[g]);
            cur_sew = (slot_q == '0) ? sew_in : sew_q;
`ifdef ALU_PACKER_MASK_EN
            cur_mask = (slot_q == '0) ? bus.mask_mode_i[g] : mask_q;
`else
            cur_mask = 1'b0;
`endif
            merged = data_q;
            if (cur_mask) begin
                merged = data_q
                       | (OP_WIDTH'(bus.res_i[g][0]) << slot_q);
            end else begin
                unique case (cur_sew)
                    SEW8: merged = data_q
                        | (OP_WIDTH'(bus.res_i[g][7:0])
                           << {slot_q[1:0], 3'b000});
                    SEW16: merged = data_q
                        | (OP_WIDTH'(bus.res_i[g][15:0])
                           << {slot_q[0], 4'b0000});
                    default: merged = bus.res_i[g];
                endcase
            end
            fill = 6'(slot_q) + 6'd1;
            done = bus.res_vld_i[g]
                && (bus.last_i[g]
                    || fill == SLOTS_PER_WORD(cur_sew, cur_mask));
            word.data = merged;
            word.be   = fill_be(cur_sew, cur_mask, fill);
        end

        always_comb begin
            data_d = data_q;
            slot_d = slot_q;
            sew_d  = sew_q;
`ifdef ALU_PACKER_MASK_EN
            mask_d = mask_q;
`endif
            if (bus.res_vld_i[g]) begin
                if (slot_q == '0) begin
                    sew_d = cur_sew;
`ifdef ALU_PACKER_MASK_EN
                    mask_d = cur_mask;
`endif
                end
                if (done) begin
                    data_d = '0;
                    slot_d = '0;
                end else begin
                    data_d = merged;
                    slot_d = slot_q + SW'(1);
                end
            end
            pop   = !empty && bus.wrdy_i[g];
            ovf_d = ovf_q || (done && full && !pop);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                slot_q <= '0;
                sew_q  <= SEW8;
                ovf_q  <= 1'b0;
`ifdef ALU_PACKER_MASK_EN
                mask_q <= 1'b0;
`endif
            end else begin
                data_q <= data_d;
                slot_q <= slot_d;
                sew_q  <= sew_d;
                ovf_q  <= ovf_d;
`ifdef ALU_PACKER_MASK_EN
                mask_q <= mask_d;
`endif
            end
        end

        alu_pack_fifo #(
            .DEPTH       (FIFO_DEPTH),
            .AFULL_THRESH(AFULL_THRESH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push_i (done),
            .din_i  (word),
            .pop_i  (pop),
            .dout_o (dout),
            .count_o(fifo_cnt_unused),
            .full_o (full),
            .empty_o(empty),
            .afull_o(afull)
        );

        // FIFO memory is not reset, so gate the outputs while empty
        assign bus.wvld_o[g]     = !empty;
        assign bus.wdata_o[g]    = empty ? '0 : dout.data;
        assign bus.wbe_o[g]      = empty ? '0 : dout.be;
        assign bus.afull_o[g]    = afull;
        assign bus.overflow_o[g] = ovf_q;
    end
endmodule

// File: tb/tb_alu_result_packer.sv
// Directed bench for alu_result_packer with a per-lane word scoreboard.
// Mask expectations follow ALU_PACKER_MASK_EN.
module tb_alu_result_packer;
    import alu_packer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    packed_word_t exp_q [4][$];

    alu_result_packer_if #(.OP_WIDTH(32), .PARALLEL_IF_NUM(4)) bus ();

    alu_result_packer #(
        .OP_WIDTH(32), .PARALLEL_IF_NUM(4),
        .FIFO_DEPTH(4), .AFULL_THRESH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_w(input int l,
                            input logic [31:0] d,
                            input logic [3:0] be);
        packed_word_t w;
        w.data = d;
        w.be   = be;
        exp_q[l].push_back(w);
    endtask

    task automatic send(input int l, input logic [31:0] r,
                        input logic [1:0] s, input logic m,
                        input logic lst);
        bus.res_i[l]        = r;
        bus.output_sew_i[l] = s;
        bus.mask_mode_i[l]  = m;
        bus.last_i[l]       = lst;
        bus.res_vld_i[l]    = 1'b1;
        @(posedge clk);
        #1;
        bus.res_vld_i[l] = 1'b0;
        bus.last_i[l]    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int l = 0; l < 4; l++) exp_q[l].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int l);
        for (int i = 0; i < 40; i++) begin
            if (exp_q[l].size() == 0 && !bus.wvld_o[l]) break;
            @(posedge clk);
            #1;
        end
        chk($sformatf("drain%0d_left", l), exp_q[l].size(), 0);
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (!rst && bus.wvld_o[l] && bus.wrdy_i[l]) begin
                packed_word_t e;
                chk($sformatf("sb%0d_has_exp", l),
                    32'(exp_q[l].size() != 0), 1);
                if (exp_q[l].size() != 0) begin
                    e = exp_q[l].pop_front();
                    chk($sformatf("sb%0d_data", l),
                        bus.wdata_o[l], e.data);
                    chk($sformatf("sb%0d_be", l),
                        32'(bus.wbe_o[l]), 32'(e.be));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] mbits;
        bus.res_i        = '0;
        bus.res_vld_i    = '0;
        bus.output_sew_i = '0;
        bus.mask_mode_i  = '0;
        bus.last_i       = '0;
        bus.wrdy_i       = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_wvld", 32'(bus.wvld_o), 0);
        chk("rst_wdata0", bus.wdata_o[0], 0);
        chk("rst_wbe", 32'(bus.wbe_o), 0);
        chk("rst_afull", 32'(bus.afull_o), 0);
        chk("rst_ovf", 32'(bus.overflow_o), 0);

        send(0, 32'hFFFFFF11, 2'b00, 1'b0, 1'b0);
        send(0, 32'hFFFFFF22, 2'b00, 1'b0, 1'b0);
        send(0, 32'hFFFFFF33, 2'b00, 1'b0, 1'b0);
        chk("b8_not_early", 32'(bus.wvld_o[0]), 0);
        expect_w(0, 32'h44332211, 4'hF);
        send(0, 32'hFFFFFF44, 2'b00, 1'b0, 1'b1);
        chk("b8_latency", 32'(bus.wvld_o[0]), 1);

        expect_w(0, 32'hBBBBAAAA, 4'hF);
        expect_w(0, 32'h0000CCCC, 4'h3);
        send(0, 32'h5555AAAA, 2'b01, 1'b0, 1'b0);
        send(0, 32'h1234BBBB, 2'b01, 1'b0, 1'b1);
        send(0, 32'h9999CCCC, 2'b01, 1'b0, 1'b1);

        expect_w(1, 32'hDEADBEEF, 4'hF);
        send(1, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0);

        mbits = 10'b11_0000_1101;
`ifdef ALU_PACKER_MASK_EN
        expect_w(0, 32'h0000030D, 4'h3);
`else
        expect_w(0, 32'h01010001, 4'hF);
        expect_w(0, 32'h00000000, 4'hF);
        expect_w(0, 32'h00000101, 4'h3);
`endif
        for (int i = 0; i < 10; i++)
            send(0, 32'hABCDEF00 | 32'(mbits[i]), 2'b00, 1'b1, i == 9);
        drain(0);
        drain(1);

        do_reset();
        bus.wrdy_i[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) expect_w(0, 32'hC0DE0000 + 32'(k), 4'hF);
            send(0, 32'hC0DE0000 + 32'(k), 2'b10, 1'b0, 1'b0);
            if (k == 1) chk("bp_afull_1", 32'(bus.afull_o[0]), 0);
            if (k == 2) chk("bp_afull_2", 32'(bus.afull_o[0]), 1);
            if (k == 4) chk("bp_ovf_4", 32'(bus.overflow_o[0]), 0);
        end
        chk("bp_ovf_5", 32'(bus.overflow_o[0]), 1);
        chk("bp_hold", bus.wdata_o[0], 32'hC0DE0001);
        bus.wrdy_i[0] = 1'b1;
        drain(0);
        chk("bp_ovf_sticky", 32'(bus.overflow_o[0]), 1);
        chk("bp_vld_done", 32'(bus.wvld_o[0]), 0);

        do_reset();
        chk("pp_ovf_rst", 32'(bus.overflow_o[0]), 0);
        bus.wrdy_i[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_w(0, 32'h5EED0000 + 32'(k), 4'hF);
            send(0, 32'h5EED0000 + 32'(k), 2'b10, 1'b0, 1'b0);
        end
        chk("pp_afull", 32'(bus.afull_o[0]), 1);
        bus.wrdy_i[0] = 1'b1;
        expect_w(0, 32'h5EED0005, 4'hF);
        send(0, 32'h5EED0005, 2'b10, 1'b0, 1'b0);
        chk("pp_ovf_push", 32'(bus.overflow_o[0]), 0);
        drain(0);
        chk("pp_ovf_end", 32'(bus.overflow_o[0]), 0);

        send(0, 32'h000000AA, 2'b00, 1'b0, 1'b0);
        send(0, 32'h000000BB, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        for (int l = 0; l < 4; l++) exp_q[l].delete();
        @(posedge clk);
        #1;
        chk("mr_wvld", 32'(bus.wvld_o[0]), 0);
        chk("mr_wdata", bus.wdata_o[0], 0);
        chk("mr_wbe", 32'(bus.wbe_o[0]), 0);
        chk("mr_ovf", 32'(bus.overflow_o[0]), 0);
        rst = 1'b0;
        expect_w(0, 32'h04030201, 4'hF);
        send(0, 32'hEEEEEE01, 2'b00, 1'b0, 1'b0);
        send(0, 32'hEEEEEE02, 2'b10, 1'b1, 1'b0);
        send(0, 32'hEEEEEE03, 2'b10, 1'b1, 1'b0);
        chk("mr_not_early", 32'(bus.wvld_o[0]), 0);
        send(0, 32'hEEEEEE04, 2'b01, 1'b0, 1'b1);
        chk("mr_vld", 32'(bus.wvld_o[0]), 1);
        drain(0);

        for (int l = 0; l < 4; l++)
            chk($sformatf("end%0d_empty", l), exp_q[l].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
